regfile_pingpong_controller: RTL and testbench

- Sequences the double-banked register file.
- A producer writes transfer blocks (two PORT_WIDTH entries per beat) into one bank while a consumer drains the other bank as entry pairs.
- Tracks per-bank ownership and fill count, and swaps banks automatically.
- Sits between the upstream operand loader and the PE read side; drives the register file's write and read control ports directly.

---
 rtl/regfile_pingpong_controller_pkg.sv | 24 ++
 rtl/regfile_bank_state.sv | 86 ++++++++
 rtl/regfile_pingpong_controller_chk.sv | 20 ++
 rtl/regfile_pingpong_controller.sv | 144 ++++++++++++++
 tb/tb_regfile_pingpong_controller.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pingpong_controller_pkg.sv
// Shared types and sizing for the ping-pong register-file controller.
// Bank lifecycle: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
package regfile_pingpong_controller_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 4;
    localparam int BLOCKS_PER_BANK    = 2 ** (ADDR_WIDTH_DEFAULT - 1);
    localparam int ENTRIES_PER_BANK   = 2 ** ADDR_WIDTH_DEFAULT;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bankState_t;

    function automatic logic isBankWritable(input bankState_t s);
        return (s == BANK_EMPTY) || (s == BANK_FILLING);
    endfunction

    function automatic logic isBankBusy(input bankState_t s);
        return (s == BANK_FULL) || (s == BANK_DRAINING);
    endfunction

endpackage

// File: rtl/regfile_bank_state.sv
// Lifecycle state and captured block count of a single register-file bank.
module regfile_bank_state
    import regfile_pingpong_controller_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fill,
    input  logic                  close,
    input  logic [ADDR_WIDTH-1:0] closeCount,
    input  logic                  drain,
    input  logic                  free,
    output bankState_t            state,
    output logic [ADDR_WIDTH-1:0] count
);

    bankState_t            state_r;
    bankState_t            stateNext_s;
    logic [ADDR_WIDTH-1:0] count_r;

    // Bank state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= BANK_EMPTY;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Next-state decode; a one-block bank closes straight from EMPTY
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            BANK_EMPTY: begin
                if (close) begin
                    stateNext_s = BANK_FULL;
                end else if (fill) begin
                    stateNext_s = BANK_FILLING;
                end else begin
                    stateNext_s = BANK_EMPTY;
                end
            end
            BANK_FILLING: begin
                if (close) begin
                    stateNext_s = BANK_FULL;
                end else begin
                    stateNext_s = BANK_FILLING;
                end
            end
            BANK_FULL: begin
                if (drain) begin
                    stateNext_s = BANK_DRAINING;
                end else begin
                    stateNext_s = BANK_FULL;
                end
            end
            BANK_DRAINING: begin
                if (free) begin
                    stateNext_s = BANK_EMPTY;
                end else begin
                    stateNext_s = BANK_DRAINING;
                end
            end
            default: stateNext_s = BANK_EMPTY;
        endcase
    end

    // Block count captured when the writer closes the bank
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {ADDR_WIDTH{1'b0}};
        end else if (close) begin
            count_r <= closeCount;
        end else begin
            count_r <= count_r;
        end
    end

    // Outputs come straight from the registers
    always_comb begin
        state = state_r;
        count = count_r;
    end

endmodule

// File: rtl/regfile_pingpong_controller_chk.sv
// Protocol checks for the ping-pong controller: no read/write bank collision.
module regfile_pingpong_controller_chk
    import regfile_pingpong_controller_pkg::*;
(
    input logic       clock,
    input logic       reset,
    input logic       writeEnable,
    input logic       writeBank,
    input logic       rdValid,
    input logic       readBank,
    input bankState_t readBankState
);

    collisionFree: assert property (@(posedge clock) disable iff (reset)
        !(writeEnable && rdValid && (writeBank == readBank)));

    readOnlyWhileDraining: assert property (@(posedge clock) disable iff (reset)
        rdValid |-> (readBankState == BANK_DRAINING));

endmodule

// File: rtl/regfile_pingpong_controller.sv
// Ping-pong sequencer for the double-banked register file: the producer fills
// one bank while the consumer drains the other as even/odd entry pairs.
module regfile_pingpong_controller
    import regfile_pingpong_controller_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wrValid,
    input  logic                  wrLast,
    output logic                  wrReady,
    output logic                  writeEnable,
    output logic                  writeBank,
    output logic [ADDR_WIDTH-2:0] writeAddrTransferBlock,
    output logic                  readBank,
    output logic [ADDR_WIDTH-1:0] readAddr0,
    output logic [ADDR_WIDTH-1:0] readAddr1,
    output logic                  rdValid,
    output logic                  rdLast,
    input  logic                  rdReady,
    output logic [1:0]            bankFull
);

    localparam int BW = ADDR_WIDTH - 1;
    localparam logic [BW-1:0] LAST_BLOCK = {BW{1'b1}};

    logic                  writeBank_r;
    logic [BW-1:0]         wrPtr_r;
    logic                  readBank_r;
    logic [BW-1:0]         pairPtr_r;
    logic                  rdValid_r;

    bankState_t            bankState_s [2];
    logic [ADDR_WIDTH-1:0] bankCount_s [2];

    logic                  wrReady_s;
    logic                  wrAccept_s;
    logic                  wrClose_s;
    logic                  drainStart_s;
    logic                  rdLast_s;
    logic                  rdAccept_s;
    logic                  rdFree_s;
    logic [BW-1:0]         pairNext_s;

    // Handshake decode for both sides
    always_comb begin
        wrReady_s    = isBankWritable(bankState_s[writeBank_r]);
        wrAccept_s   = wrValid & wrReady_s;
        wrClose_s    = wrAccept_s & (wrLast | (wrPtr_r == LAST_BLOCK));
        drainStart_s = (bankState_s[readBank_r] == BANK_FULL);
        rdLast_s     = rdValid_r &
                       ({1'b0, pairPtr_r} == (bankCount_s[readBank_r] - ADDR_WIDTH'(1)));
        rdAccept_s   = rdValid_r & rdReady;
        rdFree_s     = rdAccept_s & rdLast_s;
        if (rdAccept_s) begin
            pairNext_s = pairPtr_r + BW'(1);
        end else begin
            pairNext_s = pairPtr_r;
        end
    end

    // Write pointer and write-bank selection
    always_ff @(posedge clock) begin
        if (reset) begin
            writeBank_r <= 1'b0;
            wrPtr_r     <= {BW{1'b0}};
        end else if (wrClose_s) begin
            writeBank_r <= ~writeBank_r;
            wrPtr_r     <= {BW{1'b0}};
        end else if (wrAccept_s) begin
            writeBank_r <= writeBank_r;
            wrPtr_r     <= wrPtr_r + BW'(1);
        end else begin
            writeBank_r <= writeBank_r;
            wrPtr_r     <= wrPtr_r;
        end
    end

    // Pair pointer tracks the pair whose data is on the register-file outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            readBank_r <= 1'b0;
            pairPtr_r  <= {BW{1'b0}};
            rdValid_r  <= 1'b0;
        end else if (rdFree_s) begin
            readBank_r <= ~readBank_r;
            pairPtr_r  <= {BW{1'b0}};
            rdValid_r  <= 1'b0;
        end else if (drainStart_s) begin
            readBank_r <= readBank_r;
            pairPtr_r  <= {BW{1'b0}};
            rdValid_r  <= 1'b1;
        end else begin
            readBank_r <= readBank_r;
            pairPtr_r  <= pairNext_s;
            rdValid_r  <= rdValid_r;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : gBank
        regfile_bank_state #(
            .ADDR_WIDTH (ADDR_WIDTH)
        ) uBankState (
            .clock      (clock),
            .reset      (reset),
            .fill       (wrAccept_s && (writeBank_r == 1'(b))),
            .close      (wrClose_s && (writeBank_r == 1'(b))),
            .closeCount ({1'b0, wrPtr_r} + ADDR_WIDTH'(1)),
            .drain      (drainStart_s && (readBank_r == 1'(b))),
            .free       (rdFree_s && (readBank_r == 1'(b))),
            .state      (bankState_s[b]),
            .count      (bankCount_s[b])
        );
    end

    regfile_pingpong_controller_chk uChk (
        .clock         (clock),
        .reset         (reset),
        .writeEnable   (wrAccept_s),
        .writeBank     (writeBank_r),
        .rdValid       (rdValid_r),
        .readBank      (readBank_r),
        .readBankState (bankState_s[readBank_r])
    );

    // Port drive; read addresses lead the pair pointer by one accepted beat
    always_comb begin
        wrReady                = wrReady_s;
        writeEnable            = wrAccept_s;
        writeBank              = writeBank_r;
        writeAddrTransferBlock = wrPtr_r;
        readBank               = readBank_r;
        readAddr0              = {pairNext_s, 1'b0};
        readAddr1              = {pairNext_s, 1'b1};
        rdValid                = rdValid_r;
        rdLast                 = rdLast_s;
        bankFull               = 2'b00;
        for (int i = 0; i < 2; i++) begin
            bankFull[i] = isBankBusy(bankState_s[i]);
        end
    end

endmodule

// File: tb/tb_regfile_pingpong_controller.sv
// Self-checking bench: behavioural register file plus a bank-level reference model.
module tb_regfile_pingpong_controller;

    localparam int AW     = 4;
    localparam int BLOCKS = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          wrValid = 1'b0, wrLast = 1'b0, rdReady = 1'b0;
    logic          wrReady, writeEnable, writeBank, readBank, rdValid, rdLast;
    logic [AW-2:0] writeAddrTransferBlock;
    logic [AW-1:0] readAddr0, readAddr1;
    logic [1:0]    bankFull;

    always #5 clock = ~clock;

    regfile_pingpong_controller #(.ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .wrValid(wrValid), .wrLast(wrLast), .wrReady(wrReady),
        .writeEnable(writeEnable), .writeBank(writeBank),
        .writeAddrTransferBlock(writeAddrTransferBlock), .readBank(readBank),
        .readAddr0(readAddr0), .readAddr1(readAddr1), .rdValid(rdValid), .rdLast(rdLast),
        .rdReady(rdReady), .bankFull(bankFull)
    );

    // Register file: two entries written per block, read address registered
    logic [15:0] mem [0:1][0:15];
    logic [15:0] wrData0, wrData1, rdData0, rdData1;
    always @(posedge clock) begin
        if (writeEnable) begin
            mem[writeBank][{writeAddrTransferBlock, 1'b0}] <= wrData0;
            mem[writeBank][{writeAddrTransferBlock, 1'b1}] <= wrData1;
        end
        rdData0 <= mem[readBank][readAddr0];
        rdData1 <= mem[readBank][readAddr1];
    end

    typedef struct {
        logic [15:0] d0;
        logic [15:0] d1;
        bit          last;
        bit          bank;
    } beat_t;

    beat_t    fillQ[$];
    beat_t    expQ[$];
    int       modelWPtr, beatIdx, beatsSeen, lastsSeen;
    bit       modelWBank;
    bit [1:0] busyBanks;
    int       compared = 0, mismatched = 0;

    logic          obsWe, obsWrReady, obsRdValid, obsRdLast, obsWBank, obsRBank;
    logic [AW-1:0] obsRA0, obsRA1;
    logic [1:0]    obsBankFull;

    task automatic model_reset();
        fillQ.delete();
        expQ.delete();
        modelWPtr  = 0;
        modelWBank = 1'b0;
        busyBanks  = 2'b00;
        beatIdx    = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; wrValid = 1'b0; wrLast = 1'b0; rdReady = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // One clock of traffic, scored against the bank-level model
    task automatic drive_cycle(input bit v, input bit l, input bit rr);
        beat_t b;
        bit    expReady;
        @(negedge clock);
        wrValid = v; wrLast = l; rdReady = rr;
        wrData0 = 16'($urandom); wrData1 = 16'($urandom);
        #1;
        obsWe = writeEnable; obsWrReady = wrReady; obsRdValid = rdValid; obsRdLast = rdLast;
        obsWBank = writeBank; obsRBank = readBank; obsRA0 = readAddr0; obsRA1 = readAddr1;
        obsBankFull = bankFull;
        if (!reset) begin
            expReady = !busyBanks[modelWBank];
            compared++;
            if (wrReady !== expReady) begin
                mismatched++;
                $display("FAIL wr_ready: got %0b expected %0b", wrReady, expReady);
            end
            compared++;
            if (bankFull !== busyBanks) begin
                mismatched++;
                $display("FAIL bank_full: got %b expected %b", bankFull, busyBanks);
            end
            compared++;
            if (writeEnable !== (v & expReady)) begin
                mismatched++;
                $display("FAIL write_enable: got %0b expected %0b", writeEnable, v & expReady);
            end
            if (v && expReady) begin
                compared++;
                if (writeBank !== modelWBank || writeAddrTransferBlock !== 3'(modelWPtr)) begin
                    mismatched++;
                    $display("FAIL write_addr: got bank %0b blk %0d expected bank %0b blk %0d",
                             writeBank, writeAddrTransferBlock, modelWBank, modelWPtr);
                end
                b.d0 = wrData0; b.d1 = wrData1; b.bank = modelWBank; b.last = 1'b0;
                fillQ.push_back(b);
                if (l || fillQ.size() == BLOCKS) begin
                    fillQ[fillQ.size()-1].last = 1'b1;
                    foreach (fillQ[i]) expQ.push_back(fillQ[i]);
                    fillQ.delete();
                    busyBanks[modelWBank] = 1'b1;
                    modelWBank = ~modelWBank;
                    modelWPtr = 0;
                end else begin
                    modelWPtr++;
                end
            end
            if (rdValid && rr) begin
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_beat: got d0 %h d1 %h expected no beat", rdData0, rdData1);
                end else begin
                    b = expQ.pop_front();
                    if (rdData0 !== b.d0 || rdData1 !== b.d1 || rdLast !== b.last || readBank !== b.bank) begin
                        mismatched++;
                        $display("FAIL read_beat: got %h %h last %0b bank %0b expected %h %h last %0b bank %0b",
                                 rdData0, rdData1, rdLast, readBank, b.d0, b.d1, b.last, b.bank);
                    end
                    if (b.last) begin
                        busyBanks[b.bank] = 1'b0;
                        beatIdx = 0;
                    end else begin
                        beatIdx++;
                    end
                end
                beatsSeen++;
                if (rdLast) lastsSeen++;
            end
        end
    endtask

    task automatic drain_all();
        for (int i = 0; i < 300; i++) begin
            if (expQ.size() == 0 && busyBanks == 2'b00) break;
            drive_cycle(1'b0, 1'b0, 1'b1);
        end
        compared++;
        if (expQ.size() != 0 || busyBanks != 2'b00) begin
            mismatched++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", expQ.size());
        end
        drive_cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        #1;
        compared++;
        if (rdValid !== 1'b0 || rdLast !== 1'b0 || writeEnable !== 1'b0 || wrReady !== 1'b1 ||
            readBank !== 1'b0 || writeBank !== 1'b0 || bankFull !== 2'b00 || writeAddrTransferBlock !== 3'd0) begin
            mismatched++;
            $display("FAIL reset_state: got v%0b l%0b we%0b rdy%0b rb%0b wb%0b bf%b expected 0 0 0 1 0 0 00",
                     rdValid, rdLast, writeEnable, wrReady, readBank, writeBank, bankFull);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_three_blocks();
        do_reset();
        beatsSeen = 0; lastsSeen = 0;
        drive_cycle(1'b1, 1'b0, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b1);
        drive_cycle(1'b1, 1'b1, 1'b1);
        drain_all();
        compared++;
        if (beatsSeen != 3 || lastsSeen != 1 || obsBankFull !== 2'b00) begin
            mismatched++;
            $display("FAIL three_blocks: got %0d beats %0d last bf %b expected 3 1 00",
                     beatsSeen, lastsSeen, obsBankFull);
        end
    endtask

    task automatic test_forced_close();
        do_reset();
        beatsSeen = 0; lastsSeen = 0;
        for (int i = 0; i < BLOCKS; i++) drive_cycle(1'b1, 1'b0, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b1);
        compared++;
        if (obsWBank !== 1'b1) begin
            mismatched++;
            $display("FAIL forced_close_bank: got %0b expected 1", obsWBank);
        end
        drain_all();
        compared++;
        if (beatsSeen != BLOCKS || lastsSeen != 1) begin
            mismatched++;
            $display("FAIL forced_close_beats: got %0d/%0d expected 8/1", beatsSeen, lastsSeen);
        end
    endtask

    task automatic test_fill_both();
        int  writes = 0;
        bit  found = 1'b0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0);
            if (obsWe) writes++;
        end
        compared++;
        if (writes != 2 * BLOCKS || obsWrReady !== 1'b0) begin
            mismatched++;
            $display("FAIL fill_both: got %0d writes ready %0b expected 16 0", writes, obsWrReady);
        end
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1);
            if (obsRdValid && obsRdLast) begin
                found = 1'b1;
                break;
            end
        end
        compared++;
        if (!found || obsWrReady !== 1'b0) begin
            mismatched++;
            $display("FAIL free_cycle_ready: got found %0b ready %0b expected 1 0", found, obsWrReady);
        end
        drive_cycle(1'b0, 1'b0, 1'b0);
        compared++;
        if (obsWrReady !== 1'b1) begin
            mismatched++;
            $display("FAIL ready_after_free: got %0b expected 1", obsWrReady);
        end
        drain_all();
    endtask

    task automatic test_stall();
        bit pattern [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit rr;
        do_reset();
        beatsSeen = 0;
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, (i == 5), 1'b0);
        for (int i = 0; i < 60 && expQ.size() != 0; i++) begin
            rr = pattern[i % 4];
            drive_cycle(1'b0, 1'b0, rr);
            if (obsRdValid && !rr) begin
                compared++;
                if (obsRA0 !== 4'(2 * beatIdx) || obsRA1 !== 4'(2 * beatIdx + 1)) begin
                    mismatched++;
                    $display("FAIL stall_hold: got %0d,%0d expected %0d,%0d",
                             obsRA0, obsRA1, 2 * beatIdx, 2 * beatIdx + 1);
                end
            end
        end
        drain_all();
        compared++;
        if (beatsSeen != 6) begin
            mismatched++;
            $display("FAIL stall_beats: got %0d expected 6", beatsSeen);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        beatsSeen = 0;
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, (i == 4), 1'b1);
        for (int i = 0; i < 30 && beatsSeen < 2; i++) drive_cycle(1'b0, 1'b0, 1'b1);
        @(negedge clock);
        reset = 1'b1; wrValid = 1'b0; wrLast = 1'b0; rdReady = 1'b0;
        @(negedge clock);
        #1;
        compared++;
        if (beatsSeen != 2 || rdValid !== 1'b0 || readBank !== 1'b0 || writeBank !== 1'b0 ||
            wrReady !== 1'b1 || bankFull !== 2'b00) begin
            mismatched++;
            $display("FAIL reset_mid_drain: got beats %0d v%0b rb%0b wb%0b rdy%0b bf%b expected 2 0 0 0 1 00",
                     beatsSeen, rdValid, readBank, writeBank, wrReady, bankFull);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_one_then_eight();
        int cyc[$];
        bit lst[$];
        int lastCount = 0;
        do_reset();
        drive_cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < BLOCKS; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b1);
            if (obsRdValid) begin cyc.push_back(i); lst.push_back(obsRdLast); end
        end
        for (int i = BLOCKS; i < 60 && (expQ.size() != 0 || busyBanks != 2'b00); i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1);
            if (obsRdValid) begin cyc.push_back(i); lst.push_back(obsRdLast); end
        end
        foreach (lst[i]) if (lst[i]) lastCount++;
        compared++;
        if (cyc.size() != 9 || lastCount != 2 || !lst[0] || !lst[cyc.size()-1]) begin
            mismatched++;
            $display("FAIL one_then_eight_beats: got %0d beats %0d lasts expected 9 2", cyc.size(), lastCount);
        end else begin
            compared++;
            if (cyc[1] <= cyc[0] + 1 || cyc[8] != cyc[1] + 7) begin
                mismatched++;
                $display("FAIL one_then_eight_timing: got cycles %0d %0d %0d expected gap then contiguous",
                         cyc[0], cyc[1], cyc[8]);
            end
        end
        drain_all();
    endtask

    task automatic test_random();
        bit closed = 1'b0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
        end
        if (fillQ.size() != 0) begin
            for (int i = 0; i < 100; i++) begin
                drive_cycle(1'b1, 1'b1, 1'b1);
                if (obsWe) begin closed = 1'b1; break; end
            end
            compared++;
            if (!closed) begin
                mismatched++;
                $display("FAIL random_close: got no accept expected accept");
            end
        end
        drain_all();
    endtask

    initial begin
        test_reset();
        test_three_blocks();
        test_forced_close();
        test_fill_both();
        test_stall();
        test_reset_mid_drain();
        test_one_then_eight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
